// File: rtl/psum_arb_pkg.sv
// Shared definitions for the partial-sum register arbiter.
//   SRC_P0 / SRC_P1 : source encodings, also the mux select values
//                     (0 = in1 / producer 0, 1 = in2 / producer 1)
//   CNT_WIDTH_DEF   : default width of the saturating grant counters
package psum_arb_pkg;

  localparam logic SRC_P0        = 1'b0;
  localparam logic SRC_P1        = 1'b1;
  localparam int   CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/psum_reg_arbiter_if.sv
// Handshake bundle between the two producers, the arbiter and the consumer.
//   req0_valid/req0_ready : producer 0 request / grant
//   req1_valid/req1_ready : producer 1 request / grant
//   out_valid/out_ready   : register output handshake toward the consumer
//   out_src               : source of the value currently in the register
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. Ready may depend on valid; valid must never depend on ready.
// The slave modport is the arbiter side, master is the producer/consumer side.
interface psum_reg_arbiter_if;

  logic req0_valid;
  logic req0_ready;
  logic req1_valid;
  logic req1_ready;
  logic out_valid;
  logic out_ready;
  logic out_src;

  modport slave (
    input  req0_valid, req1_valid, out_ready,
    output req0_ready, req1_ready, out_valid, out_src
  );

  modport master (
    output req0_valid, req1_valid, out_ready,
    input  req0_ready, req1_ready, out_valid, out_src
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter.
//   valid[1:0] : requests from producer 1 / producer 0
//   last       : index granted most recently
//   rr_en      : 1 = round-robin on contention, 0 = producer 0 always wins
//   enable     : a grant may be issued this cycle
//   grant[1:0] : one-hot grant (all zero when disabled or no request)
//   grant_idx  : index that would be granted (valid only when grant != 0)
module rr_arb2
  import psum_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       rr_en,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = SRC_P0;
    if (valid == 2'b11) begin
      grant_idx = rr_en ? ~last : SRC_P0;
    end else if (valid[1]) begin
      grant_idx = SRC_P1;
    end

    grant = 2'b00;
    if (enable && (valid != 2'b00)) begin
      grant = (grant_idx == SRC_P1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/psum_reg_arbiter.sv
// Shares one mux-fed enabled register between two producers.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   rr_en         : 1 = round-robin, 0 = fixed priority (producer 0 wins)
//   bus           : producer/consumer handshakes (slave side)
//   mux_sel       : register-pair select, 0 = in1 (p0), 1 = in2 (p1)
//   reg_en        : register-pair enable, load at this edge
//   grant_cnt0/1  : saturating counts of accepted transfers per producer
// The register pair itself lives in the parent; this block only steers it.
module psum_reg_arbiter
  import psum_arb_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rr_en,
  psum_reg_arbiter_if.slave    bus,
  output logic                 mux_sel,
  output logic                 reg_en,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1
);

  logic                 full;
  logic                 last;
  logic                 sel_q;
  logic                 out_src_q;
  logic [CNT_WIDTH-1:0] cnt0;
  logic [CNT_WIDTH-1:0] cnt1;

  logic                 slot_free;
  logic [1:0]           grant;
  logic                 grant_idx;

  // A grant is allowed when the register is empty or is being drained this
  // cycle. Holding off during reset drops any grant that coincides with it.
  assign slot_free = !full || bus.out_ready;

  rr_arb2 u_arb (
    .valid     ({bus.req1_valid, bus.req0_valid}),
    .last      (last),
    .rr_en     (rr_en),
    .enable    (slot_free && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign reg_en         = |grant;
  // Keep the previous select when idle so the mux does not toggle needlessly.
  assign mux_sel        = reg_en ? grant_idx : sel_q;

  assign bus.out_valid  = full;
  assign bus.out_src    = out_src_q;
  assign grant_cnt0     = cnt0;
  assign grant_cnt1     = cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      last      <= SRC_P1;  // producer 0 wins the first contested cycle
      sel_q     <= SRC_P0;
      out_src_q <= SRC_P0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      if (reg_en) begin
        // Covers simultaneous drain + grant: new value replaces old, stays full.
        full      <= 1'b1;
        last      <= grant_idx;
        sel_q     <= grant_idx;
        out_src_q <= grant_idx;
      end else if (full && bus.out_ready) begin
        full <= 1'b0;
      end

      if (grant[0] && (cnt0 != '1)) cnt0 <= cnt0 + CNT_WIDTH'(1);
      if (grant[1] && (cnt1 != '1)) cnt1 <= cnt1 + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/psum_reg_arbiter.md
# psum_reg_arbiter

Control block that shares one mux-fed enabled register (the two-input mux + enabled DFF pair used in the PE datapath) between two producers. It arbitrates their valid/ready requests, drives the mux select and register enable, and presents the registered value downstream with a valid/ready handshake. Per-source grant counters feed the power-analysis activity statistics.

## Interface
- CNT_WIDTH, 16, width of each saturating grant counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rr_en  in  1  1 = round-robin arbitration; 0 = fixed priority, req0 wins
- req0_valid  in  1  producer 0 has data on mux input in1
- req0_ready  out  1  producer 0 granted this cycle
- req1_valid  in  1  producer 1 has data on mux input in2
- req1_ready  out  1  producer 1 granted this cycle
- mux_sel  out  1  to register-pair sel: 0 = in1 (producer 0), 1 = in2 (producer 1)
- reg_en  out  1  to register-pair en: load the mux output at this edge
- out_valid  out  1  the register holds an unconsumed value
- out_ready  in  1  consumer takes the value this cycle
- out_src  out  1  source of the value in the register (0/1)
- grant_cnt0  out  CNT_WIDTH  number of accepted producer-0 transfers, saturating
- grant_cnt1  out  CNT_WIDTH  number of accepted producer-1 transfers, saturating

## Operation
- State: full (register occupied), last (last granted source), sel_q (held select), out_src, two counters.
- slot_free = !full || out_ready. No grant when slot_free = 0.
- Arbitration when slot_free:
  - Only one valid: grant it.
  - Both valid, rr_en=1: grant !last.
  - Both valid, rr_en=0: grant 0.
- reqN_ready = grant to N. ready may depend on valid; producers must not make valid depend on ready.
- reg_en = grant0 | grant1.
- mux_sel = granted index when a grant occurs, otherwise sel_q. The select holds to avoid needless mux toggling.
- On a grant edge:
  - full ← 1
  - last, sel_q, out_src ← granted index
  - granted counter +1, saturating at all-ones
- Drain without grant (full && out_ready && no grant): full ← 0. out_src is held.
- Simultaneous drain and grant: the new value replaces the old at the same edge and full stays 1. Throughput is 1 transfer per cycle.
- Counters update on the grant only, not on the drain.
- A change of rr_en takes effect on the same-cycle arbitration. last keeps updating in both modes.

## Timing
- Reset values: full=0, out_valid=0, last=1 (so producer 0 wins the first contested cycle), sel_q=0, mux_sel=0 when idle, out_src=0, counters=0, ready outputs=0 when no valid.
- Latency: data granted at edge k is visible at the register output with out_valid=1 after edge k (cycle k+1).
- out_valid = full, registered. req*_ready, reg_en and mux_sel are combinational from registered state and inputs; there is no combinational path from out_ready to out_valid.
- Reset asserted mid-transfer: all state returns to reset values at that edge. A pending grant is dropped (reg_en forced 0 while rst=1), and the register-pair contents become don't-care because out_valid=0.
- Backpressure: while full && !out_ready, both ready outputs are 0 and reg_en is 0, so the register holds.

## Structure
- Shared package `psum_arb_pkg`: SRC_P0=1'b0, SRC_P1=1'b1, CNT_WIDTH default.
- Sub-module `rr_arb2`: combinational 2-way arbiter with inputs valid[1:0], last, rr_en, enable (slot_free) and outputs grant[1:0], grant_idx.
- The top holds the state registers, counters and select-hold logic. The datapath register pair is instantiated by the parent, not inside this block.

## Test plan
- Reset, then req0_valid=1 only, out_ready=1 → cycle 0: req0_ready=1, reg_en=1, mux_sel=0; cycle 1: out_valid=1, out_src=0, grant_cnt0=1.
- Both valid continuously, rr_en=1, out_ready=1 → grants 0,1,0,1…; mux_sel alternates; after 10 cycles grant_cnt0=5, grant_cnt1=5.
- Both valid, rr_en=0 → only producer 0 is granted; req1_ready stays 0; grant_cnt1 stays 0.
- Register full, out_ready=0 for 3 cycles, req1_valid=1 → ready=0 and reg_en=0 throughout, mux_sel held at sel_q. Then out_ready=1 → same-cycle grant to 1, out_valid stays 1, out_src=1.
- Idle after a producer-1 transfer → mux_sel stays 1. Drain with no request → out_valid falls next cycle and out_src stays 1.
- Preload grant_cnt0 to 2^CNT_WIDTH−1 (force, or CNT_WIDTH=4 with 16 grants), then one more grant → count stays all-ones. Then rst=1 during a grant → reg_en=0 and all outputs return to reset values next cycle.
